// File: rtl/frame_generator.sv
// Sender-side frame generator: sequences rows/columns, inserts FAS/ARQ/MFAS/stuff overhead
// and pulls payload over ready/valid. Define FRAME_GEN_BIP8_EN to carry a BIP-8 in row 0 col 8.
module frame_generator #(
  parameter int DATA_W    = 8,
  parameter int ROWS      = 4,
  parameter int COLS      = 1041,
  parameter int OH_COLS   = 16,
  parameter int STUFF_COL = 1040
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic                    i_arq_en,
  input  logic [DATA_W-1:0]       i_pyld_data,
  input  logic                    i_pyld_valid,
  output logic                    o_pyld_rdy,
  output logic [DATA_W-1:0]       o_frame_data,
  output logic                    o_frame_data_valid,
  output logic                    o_frame_data_fas,
  output logic                    o_frame_eof,
  output logic [$clog2(ROWS)-1:0] o_row_cnt,
  output logic [$clog2(COLS)-1:0] o_col_cnt,
  output logic [7:0]              o_mfas,
  output logic                    o_underrun,
  output logic [15:0]             o_underrun_cnt
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

  state_t            state, state_nxt;
  logic [RW-1:0]     row;
  logic [CW-1:0]     col;
  logic [7:0]        mfas;
  logic              arq_q;
  logic              active, at_start, at_end, is_pyld;
  logic [7:0]        oh_byte;
  logic [7:0]        bip_hold;
  logic [DATA_W-1:0] word;

  assign active     = (state != IDLE);
  assign at_start   = (row == '0) && (col == '0);
  assign at_end     = (row == ROW_LAST) && (col == COL_LAST);
  assign is_pyld    = (col >= CW'(OH_COLS)) && (col != CW'(STUFF_COL));
  assign o_pyld_rdy = active && is_pyld;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // A stop seen on the final word of a frame lands in LAST, so the following frame still completes.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_en)   state_nxt = RUN;
      RUN:     if (!i_en)  state_nxt = LAST;
      LAST:    if (at_end) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      row   <= '0;
      col   <= '0;
      mfas  <= '0;
      arq_q <= 1'b0;
    end else if (active) begin
      if (at_start) arq_q <= i_arq_en;
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      if (at_end) mfas <= mfas + 8'd1;
    end
  end

  always_comb begin
    oh_byte = 8'h00;
    if (row == '0) begin
      if (col < CW'(3))       oh_byte = 8'hF6;
      else if (col < CW'(6))  oh_byte = 8'h28;
      else if (col == CW'(6)) oh_byte = arq_q ? 8'hFF : 8'h00;
      else if (col == CW'(7)) oh_byte = mfas;
      else if (col == CW'(8)) oh_byte = bip_hold;
    end
    word = '0;
    if (is_pyld) begin
      if (i_pyld_valid) word = i_pyld_data;
    end else begin
      word[7:0] = oh_byte;
    end
  end

`ifdef FRAME_GEN_BIP8_EN
  // Accumulator and held result both clear while idle so a restarted stream begins with 0x00.
  logic [7:0] bip_acc;
  logic [7:0] bip_nxt;
  assign bip_nxt = bip_acc ^ (is_pyld ? word[7:0] : 8'h00);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bip_acc  <= '0;
      bip_hold <= '0;
    end else if (!active) begin
      bip_acc  <= '0;
      bip_hold <= '0;
    end else if (at_end) begin
      bip_hold <= bip_nxt;
      bip_acc  <= '0;
    end else begin
      bip_acc  <= bip_nxt;
    end
  end
`else
  assign bip_hold = 8'h00;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_frame_data       <= '0;
      o_frame_data_valid <= 1'b0;
      o_frame_data_fas   <= 1'b0;
      o_frame_eof        <= 1'b0;
      o_row_cnt          <= '0;
      o_col_cnt          <= '0;
      o_mfas             <= '0;
      o_underrun         <= 1'b0;
      o_underrun_cnt     <= '0;
    end else begin
      o_frame_data_valid <= active;
      o_frame_data       <= active ? word : '0;
      o_frame_data_fas   <= active && at_start;
      o_frame_eof        <= active && at_end;
      o_row_cnt          <= active ? row : '0;
      o_col_cnt          <= active ? col : '0;
      if (active) o_mfas <= mfas;
      o_underrun         <= o_pyld_rdy && !i_pyld_valid;
      if (o_pyld_rdy && !i_pyld_valid && (o_underrun_cnt != 16'hFFFF))
        o_underrun_cnt <= o_underrun_cnt + 16'd1;
    end
  end

endmodule

// File: doc/frame_generator.md
Name: frame_generator

Overview:
- Parametrised successor to the sender-side frame mapper. Owns its own row/column sequencing instead of taking counts from outside.
- Inserts FAS, ARQ flag, multiframe counter (MFAS) and fixed-stuff overhead, and pulls client payload through a ready/valid handshake.
- Sits in the sender map path between the client payload source and the line interface.
- Adds start/stop control at frame boundaries and underrun detection with zero-fill.

Parameters:
- DATA_W, 8: payload/line word width, must be >= 8. Overhead constants occupy bits [7:0]; upper bits are 0.
- ROWS, 4: rows per frame.
- COLS, 1041: columns per row, indexed 0..COLS-1.
- OH_COLS, 16: overhead columns at the start of every row. Must be >= 9.
- STUFF_COL, 1040: fixed-stuff column, in every row. Must satisfy OH_COLS <= STUFF_COL < COLS.

Ports:
- i_clk, in, 1: clock.
- i_rst_n, in, 1: asynchronous active-low reset.
- i_en, in, 1: frame generation enable.
- i_arq_en, in, 1: ARQ flag; sampled at each frame start.
- i_pyld_data, in, DATA_W: client payload word.
- i_pyld_valid, in, 1: payload word valid.
- o_pyld_rdy, out, 1: block will consume a payload word this cycle.
- o_frame_data, out, DATA_W: line word.
- o_frame_data_valid, out, 1: line word valid.
- o_frame_data_fas, out, 1: high on row 0 col 0 word.
- o_frame_eof, out, 1: high on row ROWS-1 col COLS-1 word.
- o_row_cnt, out, $clog2(ROWS): row of the word on o_frame_data.
- o_col_cnt, out, $clog2(COLS): column of the word on o_frame_data.
- o_mfas, out, 8: MFAS value of the current frame.
- o_underrun, out, 1: one-cycle pulse, payload slot filled with zero.
- o_underrun_cnt, out, 16: saturating underrun count.

Behaviour:
- Reset (async assert, sync deassert):
  - All outputs 0.
  - Internal row/col position = 0; MFAS = 0; state = IDLE.
- State machine:
  - IDLE: position held at 0; o_pyld_rdy = 0; o_frame_data_valid = 0. Goes to RUN when i_en = 1.
  - RUN: position advances one word per cycle. Column wraps COLS-1 -> 0 with row+1; row wraps ROWS-1 -> 0. If i_en = 0 is seen, goes to LAST.
  - LAST: finishes the current frame. At position ROWS-1/COLS-1 goes to IDLE. Re-asserting i_en in LAST does not cancel the stop. If i_en = 0 coincides with the final word of a frame, the stop applies to the next frame.
- Timing and latency:
  - o_pyld_rdy is combinational from state/position: 1 only in RUN/LAST at a payload position.
  - All o_frame_* outputs, o_row_cnt and o_col_cnt are registered, one cycle after the position they describe.
  - o_frame_data_valid = 1 on every cycle following a RUN/LAST position, so frames are contiguous with no gaps.
- Word content by position:
  - Row 0, cols 0-2: 0xF6.
  - Row 0, cols 3-5: 0x28.
  - Row 0, col 6: 0xFF if the latched ARQ flag = 1, else 0x00.
  - Row 0, col 7: MFAS.
  - Row 0, col 8: BIP or 0x00 (see Optional Feature).
  - Row 0, cols 9..OH_COLS-1: 0x00.
  - Rows 1..ROWS-1, cols 0..OH_COLS-1: 0x00.
  - Any row, STUFF_COL: 0x00.
  - All other positions are payload positions.
- ARQ latch: i_arq_en is latched at the row 0 col 0 position and held for the whole frame. Mid-frame changes take effect next frame.
- Payload handshake:
  - A word is consumed when o_pyld_rdy & i_pyld_valid, and output next cycle.
  - If o_pyld_rdy & !i_pyld_valid: output 0, o_underrun pulses, o_underrun_cnt increments and saturates at 0xFFFF.
  - i_pyld_valid outside payload positions is ignored and never consumed.
- MFAS: increments by 1 after each completed frame's final word; wraps 0xFF -> 0x00. It is not reset by IDLE.
- o_frame_data_fas: high for the row 0 col 0 word only.
- o_frame_eof: high for the last word only.
- Reset mid-frame: frame is abandoned; after release, generation restarts at row 0 col 0 with MFAS = 0.

Optional Feature:
- Macro: FRAME_GEN_BIP8_EN.
- Defined:
  - An 8-bit XOR accumulator runs over bits [7:0] of every payload-position output word of frame N, including underrun zeros.
  - At frame end the result is transferred to a holding register and the accumulator clears.
  - Row 0 col 8 of frame N+1 carries the held value.
  - The first frame after reset or after leaving IDLE carries 0x00.
- Not defined: row 0 col 8 = 0x00; no accumulator logic.

Test Plan:
- Test 1, basic frame (defaults):
  - Stimulus: reset, i_en = 1, i_arq_en = 1, payload always valid with incrementing data.
  - Response: first valid word 0xF6 with fas = 1. Words 0-8 = F6 F6 F6 28 28 28 FF 00 00. First o_pyld_rdy at row 0 col 16. Col 1040 = 0x00. Exactly 4096 payload words per frame. eof on word 4163.
- Test 2, MFAS sequencing:
  - Stimulus: run 257 frames.
  - Response: frame 1 col 7 = 0x01; frame 255 = 0xFF; frame 256 = 0x00.
- Test 3, underrun:
  - Stimulus: drop i_pyld_valid for 3 payload slots in row 1.
  - Response: three 0x00 payload words, three o_underrun pulses, o_underrun_cnt = 3. Following data resumes without loss.
- Test 4, stop request:
  - Stimulus: drop i_en at row 2 col 500.
  - Response: frame runs to row 3 col 1040 with eof, then valid = 0 and rdy = 0. Re-asserting i_en starts a new frame with MFAS + 1.
- Test 5, async reset mid-frame:
  - Stimulus: assert i_rst_n = 0 at row 1 col 300.
  - Response: all outputs 0 immediately, without waiting for a clock. After release, restart at row 0 col 0 with MFAS = 0 and ARQ byte reflecting current i_arq_en.
- Test 6, BIP (FRAME_GEN_BIP8_EN defined):
  - Stimulus: frame 0 payload all 0x00 except one 0xA5.
  - Response: frame 0 col 8 = 0x00; frame 1 col 8 = 0xA5. With the macro undefined, both frames show 0x00.
